// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scanner: active-low glyphs,
// the scan state encoding and the anode helpers.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] AN_OFF = 8'hFF;

    typedef enum logic {
        GUARD = 1'b0,
        LIT   = 1'b1
    } state_t;

    // Active-low anode pattern with only digit idx enabled.
    function automatic logic [7:0] an_select(input logic [2:0] idx);
        an_select = ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus between the digit producers and the seg7_scan driver:
// packed digits, DP mask and enable in; board pins and frame pulse out.
interface seg7_scan_if;
    logic        en;
    logic [31:0] iData;
    logic [7:0]  iDp;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        frame_done;

    modport master (
        output en, iData, iDp,
        input  AN, SEG, DP, frame_done
    );

    modport slave (
        input  en, iData, iDp,
        output AN, SEG, DP, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph ({g,f,e,d,c,b,a}).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Glyph lookup; A-F use the conventional A,b,C,d,E,F shapes.
    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed eight-digit seven-segment driver with inter-digit blanking
// guard and per-frame input snapshot. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan #(
    parameter int DWELL = 1000,
    parameter int GUARD = 4
) (
    input logic         O_CLK,
    input logic         rst,
    seg7_scan_if.slave  bus
);
    import seg7_pkg::*;

    localparam int MAX_PH = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int PW     = $clog2(MAX_PH + 1);
    localparam logic [PW-1:0] D_LAST = PW'(DWELL - 1);
    localparam logic [PW-1:0] G_LAST = (GUARD > 0) ? PW'(GUARD - 1) : '0;

    state_t         state_r;
    logic [2:0]     idx_r;
    logic [PW-1:0]  phase_r;
    logic           armed_r;
    logic [31:0]    snap_data_r;
    logic [7:0]     snap_dp_r;
    logic [7:0]     an_r;
    logic [6:0]     seg_r;
    logic           dp_r;
    logic           fd_r;

    state_t         nxt_state_s;
    logic [2:0]     nxt_idx_s;
    logic [PW-1:0]  nxt_phase_s;
    logic           enter0_s;
    logic [31:0]    snap_data_s;
    logic [7:0]     snap_dp_s;
    logic [3:0]     nib_s;
    logic [6:0]     glyph_s;
    logic [7:0]     lzb_s;
    logic           fd_nxt_s;

    // Scan sequencing: armed_r makes the first advance after reset land on the
    // opening cycle of the digit-0 slot so the snapshot is taken there.
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r;
        nxt_phase_s = phase_r;
        enter0_s    = 1'b0;
        if (armed_r) begin
            nxt_idx_s   = 3'd0;
            nxt_phase_s = '0;
            enter0_s    = 1'b1;
            if (GUARD > 0) begin
                nxt_state_s = seg7_pkg::GUARD;
            end else begin
                nxt_state_s = seg7_pkg::LIT;
            end
        end else if (state_r == seg7_pkg::GUARD) begin
            if (phase_r == G_LAST) begin
                nxt_state_s = seg7_pkg::LIT;
                nxt_phase_s = '0;
            end else begin
                nxt_phase_s = phase_r + 1'b1;
            end
        end else begin
            if (phase_r == D_LAST) begin
                nxt_idx_s   = idx_r + 3'd1;
                nxt_phase_s = '0;
                enter0_s    = (idx_r == 3'd7);
                if (GUARD > 0) begin
                    nxt_state_s = seg7_pkg::GUARD;
                end else begin
                    nxt_state_s = seg7_pkg::LIT;
                end
            end else begin
                nxt_phase_s = phase_r + 1'b1;
            end
        end
    end

    // Outputs are built from the next state, so the fresh snapshot is bypassed in.
    assign snap_data_s = enter0_s ? bus.iData : snap_data_r;
    assign snap_dp_s   = enter0_s ? bus.iDp   : snap_dp_r;
    assign nib_s       = snap_data_s[{nxt_idx_s, 2'b00} +: 4];
    assign fd_nxt_s    = (nxt_state_s == seg7_pkg::LIT) && (nxt_idx_s == 3'd7) &&
                         (nxt_phase_s == D_LAST);

    seg7_decode u_decode (
        .nib (nib_s),
        .seg (glyph_s)
    );

`ifdef SEG7_LZB_EN
    // Digit k is a leading blank while every nibble and DP bit from 7 down to k is zero.
    always_comb begin
        logic lead;
        lead  = 1'b1;
        lzb_s = 8'h00;
        for (int k = 7; k >= 1; k--) begin
            lead     = lead & (snap_data_s[4*k +: 4] == 4'h0) & ~snap_dp_s[k];
            lzb_s[k] = lead;
        end
    end
`else
    assign lzb_s = 8'h00;
`endif

    // Scan FSM with registered pin outputs; en low blanks the pins and freezes the scan.
    always_ff @(posedge O_CLK) begin
        if (rst) begin
            state_r     <= seg7_pkg::GUARD;
            idx_r       <= 3'd0;
            phase_r     <= '0;
            armed_r     <= 1'b1;
            snap_data_r <= 32'h0000_0000;
            snap_dp_r   <= 8'h00;
            an_r        <= AN_OFF;
            seg_r       <= SEG_BLANK;
            dp_r        <= 1'b1;
            fd_r        <= 1'b0;
        end else if (!bus.en) begin
            an_r  <= AN_OFF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
            fd_r  <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            idx_r       <= nxt_idx_s;
            phase_r     <= nxt_phase_s;
            armed_r     <= 1'b0;
            snap_data_r <= snap_data_s;
            snap_dp_r   <= snap_dp_s;
            fd_r        <= fd_nxt_s;
            if (nxt_state_s == seg7_pkg::LIT) begin
                an_r  <= lzb_s[nxt_idx_s] ? AN_OFF : an_select(nxt_idx_s);
                seg_r <= glyph_s;
                dp_r  <= ~snap_dp_s[nxt_idx_s];
            end else begin
                an_r  <= AN_OFF;
                seg_r <= SEG_BLANK;
                dp_r  <= 1'b1;
            end
        end
    end

    assign bus.AN         = an_r;
    assign bus.SEG        = seg_r;
    assign bus.DP         = dp_r;
    assign bus.frame_done = fd_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed, table-driven bench for seg7_scan with DWELL=4, GUARD=2 (48-cycle frame).
module tb_seg7_scan;

    localparam int D = 4;
    localparam int G = 2;

    localparam int EV_NONE = 0;
    localparam int EV_POKE = 1;
    localparam int EV_HOLD = 2;
    localparam int EV_RST  = 3;

    localparam logic [16:0] BLANK_EXP = {8'hFF, 7'h7F, 1'b1, 1'b0};
    localparam logic [16:0] ALL_BITS  = 17'h1FFFF;
    localparam logic [16:0] AN_FD     = {8'hFF, 7'h00, 1'b0, 1'b1};

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [55:0] segs;   // digit d glyph at [7*d +: 7]
        logic [7:0]  blank;  // digits expected to keep AN high
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[5];

    seg7_scan_if bus ();

    seg7_scan #(.DWELL(D), .GUARD(G)) dut (
        .O_CLK (clk),
        .rst   (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int d, input logic [16:0] exp,
                       input logic [16:0] mask);
        logic [16:0] act;
        act = {bus.AN, bus.SEG, bus.DP, bus.frame_done};
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s digit %0d: got {AN,SEG,DP,fd}=%h required %h (mask %h)",
                     name, d, act, exp, mask);
        end
    endtask

    // Walk one full frame cycle by cycle; an optional event fires after the
    // LIT cycle ev_c of digit ev_d has been checked.
    task automatic check_frame(input int vi, input int ev, input int ev_d, input int ev_c,
                               input logic [31:0] ev_v);
        logic [7:0]  one;
        logic [7:0]  an_exp;
        logic [16:0] exp;
        one = 8'h01;
        bus.iData = tbl[vi].data;
        bus.iDp   = tbl[vi].dp;
        for (int d = 0; d < 8; d++) begin
            for (int g = 0; g < G; g++) begin
                step();
                chk("guard", d, BLANK_EXP, ALL_BITS);
            end
            for (int c = 0; c < D; c++) begin
                step();
                an_exp = ~(one << d);
                exp = {an_exp, tbl[vi].segs[7*d +: 7], ~tbl[vi].dp[d],
                       (d == 7 && c == D - 1) ? 1'b1 : 1'b0};
                if (tbl[vi].blank[d]) begin
                    exp[16:9] = 8'hFF;
                    chk("lzb", d, exp, AN_FD);
                end else begin
                    chk("lit", d, exp, ALL_BITS);
                end
                if (d == ev_d && c == ev_c) begin
                    case (ev)
                        EV_POKE: begin
                            bus.iData = ev_v;
                        end
                        EV_HOLD: begin
                            bus.en = 1'b0;
                            for (int h = 0; h < 10; h++) begin
                                step();
                                chk("en_blank", d, BLANK_EXP, ALL_BITS);
                            end
                            bus.en = 1'b1;
                        end
                        EV_RST: begin
                            rst = 1'b1;
                            for (int h = 0; h < 3; h++) begin
                                step();
                                chk("rst_mid", d, BLANK_EXP, ALL_BITS);
                            end
                            rst = 1'b0;
                            return;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{32'h12345678, 8'h01,
                   {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'h00};
        tbl[1] = '{32'hFFFFFFFF, 8'h00,
                   {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, 8'h00};
        tbl[2] = '{32'h89ABCDEF, 8'hA5,
                   {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'h00};
        tbl[3] = '{32'h00000120, 8'h00,
                   {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40}, 8'h00};
        tbl[4] = '{32'h00000000, 8'h10,
                   {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h00};
`ifdef SEG7_LZB_EN
        tbl[3].blank = 8'hF8;
        tbl[4].blank = 8'hE0;
`endif

        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.iData = tbl[0].data;
        bus.iDp   = tbl[0].dp;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset", 0, BLANK_EXP, ALL_BITS);
        end
        rst = 1'b0;

        // Table frames back to back; the first one also covers the post-reset latency.
        for (int i = 0; i < 5; i++) begin
            check_frame(i, EV_NONE, -1, -1, 32'h0);
        end

        // Input change mid-frame is held off until the next frame.
        check_frame(0, EV_POKE, 3, 0, 32'hFFFFFFFF);
        check_frame(1, EV_NONE, -1, -1, 32'h0);

        // Enable dropped during digit 5, then on the cycle frame_done would fire.
        check_frame(2, EV_HOLD, 5, 1, 32'h0);
        check_frame(0, EV_HOLD, 7, D - 2, 32'h0);

        // Reset mid-frame aborts without frame_done and re-captures the snapshot.
        check_frame(2, EV_RST, 6, 1, 32'h0);
        check_frame(3, EV_NONE, -1, -1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for the Nexys 4 DDR eight-digit seven-segment display. It consumes a 32-bit packed nibble word (digit 7 in bits 31:28 down to digit 0 in bits 3:0) and an 8-bit decimal-point mask, as produced by the stopwatch/counter blocks. It scans one digit at a time onto the board's active-low anode and cathode pins. A short blanking guard between digits suppresses ghosting, and a frame snapshot keeps each displayed frame consistent.

## Interface
Parameters:
- DWELL, 1000: lit cycles per digit; must be ≥ 1.
- GUARD, 4: all-anodes-off cycles before each digit; must be ≥ 0, and 0 removes the guard phase.

Ports:
- O_CLK  in  1  scan clock.
- rst  in  1  reset: synchronous, active-high; clock O_CLK.
- en  in  1  display enable; low blanks the display and holds scan state.
- iData  in  32  packed hex/BCD digits, nibble k = digit k.
- iDp  in  8  decimal-point mask; bit k = 1 lights the DP of digit k.
- AN  out  8  anodes, active-low; AN[k] drives digit k (digit 0 is rightmost).
- SEG  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal-point cathode, active-low.
- frame_done  out  1  one-cycle pulse at the end of each full 8-digit frame.

## Operation
- FSM states:
  - GUARD: AN=8'hFF, SEG=7'h7F, DP=1 for GUARD cycles.
  - LIT: AN has only bit idx low; SEG/DP show digit idx for DWELL cycles.
  - LIT → GUARD, idx+1 mod 8.
  - When GUARD=0, LIT goes directly to LIT of the next digit.
- idx counts 0→7 and wraps to 0.
- Snapshot: iData/iDp are captured into internal registers on the cycle the FSM enters digit 0 (GUARD phase, or LIT if GUARD=0). Input changes within a frame are not displayed until the next frame.
- Decode: 0-9 standard glyphs; A-F as A,b,C,d,E,F.
  - 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000, A → 7'b0001000, F → 7'b0001110.
- DP = ~snapshot_dp[idx] during LIT, 1 otherwise.
- frame_done is asserted on the last LIT cycle of digit 7.
- en=0:
  - Outputs are forced to blank (AN=FF, SEG=7F, DP=1) on the next edge.
  - The phase counter, idx, and state are frozen, and frame_done=0.
  - On en=1, scanning resumes exactly where it stopped.
- Reset values:
  - AN=8'hFF, SEG=7'h7F, DP=1, frame_done=0.
  - idx=0, state=GUARD, phase counter=0, snapshot=0.
- Reset asserted mid-frame restarts at digit 0 GUARD on the cycle after deassertion; it overrides en.
- Phase counter width is $clog2(max(DWELL,GUARD)+1).

## Timing
- All outputs are registered and change on the same O_CLK edge as the state/phase transition they reflect.
- Frame length is 8×(GUARD+DWELL) cycles while en=1.
- The snapshot is taken on the first cycle of the digit-0 slot.
- frame_done fires exactly once per frame, one cycle before the digit-0 slot of the next frame.
- Latency from an iData change to its display is at most one frame plus GUARD+1 cycles.
- If en falls on the cycle frame_done would fire, the pulse is suppressed. It fires when en returns and that final LIT cycle completes.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking.
  - During its LIT slot, digit k (k = 7..1) keeps AN[k]=1 if snapshot nibbles 7..k are all zero and iDp bits 7..k are all zero.
  - Slot timing is unchanged.
  - Digit 0 is never blanked.
- SEG7_LZB_EN undefined: every digit is always lit in its slot.

## Structure
- Package seg7_pkg holds:
  - the glyph constants (SEG_0..SEG_F, SEG_BLANK=7'h7F);
  - the state enum {GUARD, LIT};
  - AN_OFF=8'hFF.
- Sub-module seg7_decode: combinational 4-bit nibble → 7-bit active-low glyph, instantiated once on the selected nibble.

## Test plan
- Reset, DWELL=4, GUARD=2: AN=FF, SEG=7F, DP=1, frame_done=0 for the whole reset; the first digit-0 LIT occurs on cycle 3 after deassertion.
- iData=32'h12345678, iDp=8'h01:
  - AN steps FE,FD,…,7F, each for 4 cycles, with FF guards in between.
  - Digit 0 has SEG=7'h00 and DP=0.
  - frame_done pulses every 48 cycles.
- iData changes to 32'hFFFFFFFF during digit 3: the rest of the frame still shows the 1234 digits; the next frame shows F (7'b0001110) on all digits.
- en low for 10 cycles during digit 5 LIT: outputs are blank; after en returns, the remaining LIT cycles of digit 5 complete, and the frame period extends by 10.
- SEG7_LZB_EN with iData=32'h00000120: digits 7..3 keep AN high; digits 2,1,0 show 1,2,0.
- rst pulsed during digit 6: the next frame restarts at digit 0 with the snapshot re-captured, and no frame_done is issued for the aborted frame.
